// File: rtl/sb_multi_tracker.sv
// Multi-channel magic-packet scoreboard beside NUM_CH FWFT FIFOs. data_out_vld/prop_signal are combinational on the exit pop;
// err/err_ch/proto_err/chk_cnt register one cycle later. Purely observational: never stalls the datapath it watches.
module sb_multi_tracker #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int REARM  = 0,
    parameter int CNTWID = $clog2(DEPTH) + 1,
    parameter int CHKWID = 16,
    localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         start,
    input  logic [NUM_CH-1:0]         push,
    input  logic [NUM_CH-1:0]         pop,
    input  logic [NUM_CH*WIDTH-1:0]   flat_data_in,
    input  logic [NUM_CH*WIDTH-1:0]   flat_data_out,
    output logic [NUM_CH-1:0]         data_out_vld,
    output logic                      prop_signal,
    output logic                      err,
    output logic [CHW-1:0]            err_ch,
    output logic                      proto_err,
    output logic [CHKWID-1:0]         chk_cnt
);
    localparam int NW   = $clog2(NUM_CH + 1);
    localparam int SUMW = CHKWID + 1;

    typedef enum logic [1:0] {IDLE, TRACK, DONE} state_t;

    state_t            state_q [NUM_CH];
    state_t            state_d [NUM_CH];
    logic [CNTWID-1:0] occ_q   [NUM_CH];
    logic [CNTWID-1:0] occ_d   [NUM_CH];
    logic [CNTWID-1:0] pos_q   [NUM_CH];
    logic [CNTWID-1:0] pos_d   [NUM_CH];
    logic [WIDTH-1:0]  magic_q [NUM_CH];
    logic [WIDTH-1:0]  magic_d [NUM_CH];

    logic [NUM_CH-1:0] push_bad, pop_bad, push_ok, pop_ok, match, fail;
    logic              err_q, err_d, proto_q, proto_d;
    logic [CHW-1:0]    err_ch_q, err_ch_d, first_ch;
    logic [CHKWID-1:0] chk_q, chk_d;
    logic [NW-1:0]     n_exit;
    logic [SUMW-1:0]   chk_sum;

    // A push into a full FIFO or pop from an empty one is only legal when paired with the opposite op.
    always_comb begin
        push_bad     = '0;
        pop_bad      = '0;
        push_ok      = '0;
        pop_ok       = '0;
        match        = '0;
        fail         = '0;
        data_out_vld = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            pos_d[i]   = pos_q[i];
            magic_d[i] = magic_q[i];

            push_bad[i] = push[i] & ~pop[i] & (occ_q[i] == CNTWID'(DEPTH));
            pop_bad[i]  = pop[i] & ~push[i] & (occ_q[i] == '0);
            push_ok[i]  = push[i] & ~push_bad[i];
            pop_ok[i]   = pop[i] & ~pop_bad[i];
            occ_d[i]    = occ_q[i] + CNTWID'(push_ok[i]) - CNTWID'(pop_ok[i]);

            match[i]        = (flat_data_out[i*WIDTH +: WIDTH] == magic_q[i]);
            data_out_vld[i] = (state_q[i] == TRACK) & pop[i] & (pos_q[i] == CNTWID'(1));

            case (state_q[i])
                IDLE: begin
                    if (start[i] & push_ok[i]) begin
                        state_d[i] = TRACK;
                        magic_d[i] = flat_data_in[i*WIDTH +: WIDTH];
                        pos_d[i]   = occ_q[i] + CNTWID'(1) - CNTWID'(pop_ok[i]);
                    end
                end
                TRACK: begin
                    if (data_out_vld[i]) begin
                        state_d[i] = (REARM != 0) ? IDLE : DONE;
                        pos_d[i]   = '0;
                    end else if (pop_ok[i]) begin
                        pos_d[i] = pos_q[i] - CNTWID'(1);
                    end
                end
                default: ;
            endcase

            fail[i] = (data_out_vld[i] & ~match[i]) | push_bad[i] | pop_bad[i];
        end
    end

    assign prop_signal = &(~data_out_vld | match);

    always_comb begin
        first_ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (fail[i]) first_ch = CHW'(i);
        end
    end

    // err_ch is frozen once err is set, so only the first failing cycle is recorded.
    always_comb begin
        err_d    = err_q | (|fail);
        err_ch_d = (!err_q && (|fail)) ? first_ch : err_ch_q;
        proto_d  = proto_q | (|push_bad) | (|pop_bad);
        n_exit   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_exit = n_exit + NW'(data_out_vld[i]);
        end
        chk_sum = {1'b0, chk_q} + SUMW'(n_exit);
        chk_d   = chk_sum[CHKWID] ? '1 : chk_sum[CHKWID-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
                occ_q[i]   <= '0;
                pos_q[i]   <= '0;
                magic_q[i] <= '0;
            end
            err_q    <= 1'b0;
            err_ch_q <= '0;
            proto_q  <= 1'b0;
            chk_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                occ_q[i]   <= occ_d[i];
                pos_q[i]   <= pos_d[i];
                magic_q[i] <= magic_d[i];
            end
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
            proto_q  <= proto_d;
            chk_q    <= chk_d;
        end
    end

    assign err       = err_q;
    assign err_ch    = err_ch_q;
    assign proto_err = proto_q;
    assign chk_cnt   = chk_q;
endmodule
